cbus_rr_arbiter: RTL and testbench
==================================

# cbus_rr_arbiter

N-port round-robin arbiter that shares the single cached-bus (cbus) master port between the instruction cache, data cache and uncached data path. It sits between the cache/converter layer and the address-translation stage feeding `oreq`. A grant is held for a whole burst, from acceptance through the beat carrying `last`. Rotating priority guarantees that no requester starves.

## Interface
- `N`, default 2: number of requester ports, ≥ 2.
- `IDX_W`, default `$clog2(N)`: width of the grant index.

Ports:
- `clk` input, 1: clock, all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `ireqs` input, `cbus_req_t [N-1:0]`: requester requests.
- `iresps` output, `cbus_resp_t [N-1:0]`: per-requester responses.
- `oreq` output, `cbus_req_t`: the shared request to memory.
- `oresp` input, `cbus_resp_t`: the shared response from memory.
- `busy` output, 1: a grant is active.
- `grant_idx` output, `IDX_W`: currently or last granted port.

## Operation
- Two states: `IDLE` and `BUSY`.
- **Reset:** state=IDLE, `ptr`=0, `grant_idx`=0. `oreq`, all `iresps` and `busy` are 0.
- **IDLE:**
  - `oreq`=0 and all `iresps`=0.
  - If any `ireqs[i].valid`, pick the first valid port scanning `ptr`, `ptr+1`, … `ptr+N-1`, with indices taken modulo N.
  - Register the pick into `grant_idx` and go to BUSY.
- **BUSY:**
  - `oreq`=`ireqs[grant_idx]`, passed unchanged.
  - `iresps[grant_idx]`=`oresp`; every other `iresps[j]`=0.
  - `busy`=1.
  - On `oresp.ready && oresp.last`: go to IDLE and set `ptr`=`grant_idx`+1 (mod N; for non-power-of-2 N, wrap explicitly to 0).
- A non-granted requester keeps its valid asserted and sees ready=0 until it is served.
- Requesters must hold valid and all request fields stable until their `last` beat. If the granted port drops valid mid-burst, the arbiter keeps forwarding and stays in BUSY. This is a protocol violation and the bench flags it.
- Single-beat transfers (`len`=0) complete on the first ready, which carries `last`=1.
- The arbiter does not decode addresses or modify any request field.

## Timing
- Grant latency: the cycle in which valid first appears is spent in IDLE. `oreq.valid` rises the next cycle, so there is 1 cycle of arbitration overhead.
- Back-to-back transactions: after `last`, there is exactly one IDLE cycle before the next grant. This bubble is mandatory and ensures that no response beat is ever routed to two ports.
- Memory may hold ready low for any number of cycles; the arbiter waits indefinitely.
- Simultaneous events:
  - `last` arriving while other ports are valid: the next grant is computed in the following IDLE cycle using the updated `ptr`.
  - All N ports valid continuously: grants cycle k, k+1, … k+N-1, with every port served once per N transactions.
- Reset asserted mid-burst: the next cycle is IDLE, `ptr`=0 and `oreq.valid`=0. The interrupted burst is abandoned, and its requester sees no further ready.

## Structure
- `cbus_req_t` and `cbus_resp_t` already live in the shared bus package; no new typedefs are needed.
- Add `arb_state_t` (IDLE, BUSY) to the same package so that the bench can probe the arbiter state.
- One natural sub-module is `rr_pick`: combinational, with inputs valid[N] and `ptr` and outputs `idx` and `any`. Reuse it wherever rotating priority is needed.
- Expected size is about 150 lines of RTL.

## Test plan
- **Reset behaviour:** with reset held 3 cycles and all valid=1, `oreq.valid`=0 and `busy`=0 throughout. After release, port 0 is granted first and `oreq.valid` rises 2 cycles later.
- **Single requester burst:** port 1 requests `len`=3 (4 beats) and memory gives ready on every cycle. Port 1 sees 4 ready beats with `last` on beat 4, and port 0 sees ready=0 throughout. The arbiter returns to IDLE and `ptr`=0.
- **Contention:** ports 0 and 1 are both valid at `ptr`=0. Grants go 0, then 1, then 0. Each switch has exactly one IDLE cycle, and no ready beat leaks to the waiting port.
- **Wait states:** memory inserts 5 ready=0 cycles between beats. The grant holds, `oreq` stays constant, and `busy` stays 1.
- **Reset mid-burst:** reset is asserted after beat 2 of 4. The next cycle shows `oreq.valid`=0, state IDLE and `ptr`=0.
- **Fairness with N=3:** all ports are continuously valid with single-beat requests. Grants go 0, 1, 2, 0, 1, 2, and no port waits more than 2 transactions.

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cached-bus payload types and arbiter state encoding.
package cbus_rr_arbiter_pkg;

   localparam int unsigned CBUS_ADDR_W = 32;
   localparam int unsigned CBUS_DATA_W = 32;
   localparam int unsigned CBUS_LEN_W  = 8;
   localparam int unsigned CBUS_STRB_W = CBUS_DATA_W / 8;

   // Request from a cache/converter towards memory; held stable until the last beat.
   typedef struct packed {
      logic                   valid;
      logic                   is_write;
      logic [CBUS_ADDR_W-1:0] addr;
      logic [CBUS_LEN_W-1:0]  len;
      logic [CBUS_DATA_W-1:0] data;
      logic [CBUS_STRB_W-1:0] strobe;
   } cbus_req_t;

   // Per-beat response from memory.
   typedef struct packed {
      logic                   ready;
      logic                   last;
      logic [CBUS_DATA_W-1:0] data;
   } cbus_resp_t;

   // Arbiter state, visible to the bench for probing.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first valid index scanning ptr, ptr+1, ... modulo N.
module cbus_rr_arbiter_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Position ptr+off wrapped into 0..N-1 (ptr is always below N).
   function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base,
                                            input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N) s = s - N;
      return IDX_W'(s);
   endfunction

   logic [IDX_W-1:0] pos;

   // Scan from the far end back towards ptr so the nearest valid port wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      pos   = '0;
      for (int unsigned k = N; k > 0; k--) begin
         pos = rot(ptr_i, k - 1);
         if (valid_i[pos]) begin
            idx_o = pos;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter sharing one cbus master port; a grant lasts a whole burst.
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  cbus_req_t  [N-1:0]     ireqs,
   output cbus_resp_t [N-1:0]     iresps,
   output cbus_req_t              oreq,
   input  cbus_resp_t             oresp,
   output logic                   busy,
   output logic [IDX_W-1:0]       grant_idx
);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gidx_q, gidx_d;

   logic [N-1:0]     req_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   // Collect the valid bits for the picker.
   always_comb begin
      req_valid = '0;
      for (int unsigned i = 0; i < N; i++) begin
         req_valid[i] = ireqs[i].valid;
      end
   end

   cbus_rr_arbiter_rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // State, rotation pointer and grant index registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
      end
   end

   // Next state and burst routing; outputs are quiet while reset is asserted
   // so an abandoned burst never sees another ready beat.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      oreq    = '0;
      iresps  = '0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gidx_d  = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!reset) begin
               oreq           = ireqs[gidx_q];
               iresps[gidx_q] = oresp;
               busy           = 1'b1;
            end
            if (oresp.ready && oresp.last) begin
               state_d = IDLE;
               ptr_d   = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant_idx = gidx_q;

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Bench for cbus_rr_arbiter (N=3): per-cycle model compare plus directed literals.
module tb_cbus_rr_arbiter;
   import cbus_rr_arbiter_pkg::*;

   localparam int NP = 3;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   cbus_req_t  [NP-1:0] ireqs = '0;
   cbus_resp_t [NP-1:0] iresps;
   cbus_req_t           oreq;
   cbus_resp_t          oresp = '0;
   logic                busy;
   logic [IW-1:0]       grant_idx;

   always #5 clk = ~clk;

   cbus_rr_arbiter #(.N(NP), .IDX_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .ireqs     (ireqs),
      .iresps    (iresps),
      .oreq      (oreq),
      .oresp     (oresp),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus state: pending burst lengths per port, memory wait-state model.
   int pend [NP][$];
   int seq  [NP];
   int ws   = 0;
   int wcnt = 0;
   int beat = 0;
   logic rst_drive = 1'b1;

   // Behavioural model: who owns the bus (-1 = nobody) and who is first in line.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_gidx  = 0;

   // Observation logs.
   int grant_log[$];
   int gap_log[$];
   int run_log[$];
   int rdy_cnt [NP];
   int last_at [NP];
   int idle_run = 0;
   int busy_run = 0;
   logic prev_busy = 1'b0;
   logic seen_busy = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_log(input string nm, input int q[$], input int idx, input int exp);
      if (idx < q.size()) chk(nm, 128'(q[idx]), 128'(exp));
      else chk(nm, 128'hDEAD, 128'(exp));
   endtask

   // Model update at each rising edge from the inputs the DUT also sees.
   always @(posedge clk) begin : model
      int n_owner, n_ptr, n_gidx, p;
      n_owner = m_owner; n_ptr = m_ptr; n_gidx = m_gidx;
      if (reset) begin
         n_owner = -1; n_ptr = 0; n_gidx = 0;
      end else if (m_owner < 0) begin
         for (int k = NP - 1; k >= 0; k--) begin
            p = (m_ptr + k) % NP;
            for (int i = 0; i < NP; i++)
               if (i == p && ireqs[i].valid) begin n_owner = p; n_gidx = p; end
         end
      end else if (oresp.ready && oresp.last) begin
         n_ptr   = (m_owner + 1) % NP;
         n_owner = -1;
      end
      m_owner <= n_owner;
      m_ptr   <= n_ptr;
      m_gidx  <= n_gidx;
   end

   // Per-cycle compare against the model, then log grants and beats.
   always @(negedge clk) begin : cmp
      cbus_req_t e_oreq;
      cbus_resp_t [NP-1:0] e_iresps;
      logic e_busy;
      e_oreq = '0; e_iresps = '0; e_busy = 1'b0;
      if (!reset && m_owner >= 0) begin
         for (int i = 0; i < NP; i++)
            if (i == m_owner) begin
               e_oreq      = ireqs[i];
               e_iresps[i] = oresp;
               if (!ireqs[i].valid)
                  $display("FAIL protocol: granted port %0d dropped valid at %0t", i, $time);
            end
         e_busy = 1'b1;
      end
      chk("oreq", 128'(oreq), 128'(e_oreq));
      chk("iresps", 128'(iresps), 128'(e_iresps));
      chk("busy", 128'(busy), 128'(e_busy));
      chk("grant_idx", 128'(grant_idx), 128'(m_gidx));
      chk("ptr", 128'(dut.ptr_q), 128'(m_ptr));
      chk("state", 128'(dut.state_q), 128'((m_owner >= 0) ? BUSY : IDLE));

      if (busy) begin
         if (!prev_busy) begin
            grant_log.push_back(int'(grant_idx));
            if (seen_busy) gap_log.push_back(idle_run);
            busy_run = 0;
         end
         busy_run++;
      end else begin
         if (prev_busy) begin
            run_log.push_back(busy_run);
            idle_run = 0;
         end
         idle_run++;
      end
      prev_busy = busy;
      if (busy) seen_busy = 1'b1;
      for (int i = 0; i < NP; i++) begin
         if (iresps[i].ready) rdy_cnt[i]++;
         if (iresps[i].ready && iresps[i].last) last_at[i] = rdy_cnt[i];
      end
   end

   function automatic cbus_req_t make_req(input int i);
      cbus_req_t r;
      r = '0;
      if (pend[i].size() > 0) begin
         r.valid    = 1'b1;
         r.is_write = (i == 1);
         r.addr     = 32'h1000_0000 | (32'(i) << 16) | 32'(seq[i]);
         r.len      = 8'(pend[i][0]);
         r.data     = 32'hA500_0000 | 32'(i * 256 + seq[i]);
         r.strobe   = 4'hF;
      end
      return r;
   endfunction

   // One clock cycle: drive requesters, then memory, then bookkeeping.
   task automatic step();
      @(posedge clk);
      #1;
      reset = rst_drive;
      for (int i = 0; i < NP; i++) ireqs[i] = make_req(i);
      #1;
      oresp = '0;
      if (!reset && oreq.valid && wcnt >= ws) begin
         oresp.ready = 1'b1;
         oresp.last  = (beat == int'(oreq.len));
         oresp.data  = 32'hD000_0000 + 32'(beat);
      end
      @(negedge clk);
      if (reset) begin
         wcnt = 0; beat = 0;
      end else if (oreq.valid) begin
         if (oresp.ready) begin
            wcnt = 0;
            beat = oresp.last ? 0 : beat + 1;
         end else wcnt++;
      end
      for (int i = 0; i < NP; i++)
         if (!reset && iresps[i].ready && iresps[i].last) begin
            void'(pend[i].pop_front());
            seq[i]++;
         end
      #1;
   endtask

   task automatic clear_logs();
      grant_log.delete(); gap_log.delete(); run_log.delete();
      for (int i = 0; i < NP; i++) begin rdy_cnt[i] = 0; last_at[i] = 0; end
      seen_busy = 1'b0;
      idle_run  = 0;
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((pend[0].size() + pend[1].size() + pend[2].size() > 0 || busy) && n < max_cyc) begin
         step();
         n++;
      end
      chk("drain_timeout", 128'(n >= max_cyc), 128'(0));
   endtask

   task automatic do_reset();
      rst_drive = 1'b1;
      step();
      rst_drive = 1'b0;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      for (int i = 0; i < NP; i++) seq[i] = 0;

      // Reset held 3 cycles with every port valid.
      for (int i = 0; i < NP; i++) pend[i].push_back(0);
      rst_drive = 1'b1;
      repeat (3) step();
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_oreq_valid", 128'(oreq.valid), 128'(0));
      rst_drive = 1'b0;
      clear_logs();
      step();
      chk("arb_cycle_oreq_valid", 128'(oreq.valid), 128'(0));
      step();
      chk("first_grant_valid", 128'(oreq.valid), 128'(1));
      chk("first_grant_idx", 128'(grant_idx), 128'(0));
      drain(50);
      chk_log("rst_grant0", grant_log, 0, 0);
      chk_log("rst_grant1", grant_log, 1, 1);
      chk_log("rst_grant2", grant_log, 2, 2);

      // Single requester burst, 4 beats, ready every cycle.
      clear_logs();
      pend[1].push_back(3);
      drain(50);
      chk("single_p1_beats", 128'(rdy_cnt[1]), 128'(4));
      chk("single_p1_last_beat", 128'(last_at[1]), 128'(4));
      chk("single_p0_beats", 128'(rdy_cnt[0]), 128'(0));
      chk_log("single_busy_len", run_log, 0, 4);
      chk("single_ptr", 128'(dut.ptr_q), 128'(2));
      chk("single_state", 128'(dut.state_q), 128'(IDLE));

      // Contention between ports 0 and 1 starting from ptr 0.
      do_reset();
      clear_logs();
      pend[0].push_back(1); pend[0].push_back(1);
      pend[1].push_back(1);
      drain(60);
      chk_log("cont_grant0", grant_log, 0, 0);
      chk_log("cont_grant1", grant_log, 1, 1);
      chk_log("cont_grant2", grant_log, 2, 0);
      chk_log("cont_gap0", gap_log, 0, 1);
      chk_log("cont_gap1", gap_log, 1, 1);
      chk("cont_p0_beats", 128'(rdy_cnt[0]), 128'(4));
      chk("cont_p1_beats", 128'(rdy_cnt[1]), 128'(2));
      chk("cont_p2_beats", 128'(rdy_cnt[2]), 128'(0));

      // Wait states: 5 idle-ready cycles before each of 2 beats.
      clear_logs();
      ws = 5;
      pend[2].push_back(1);
      drain(200);
      ws = 0;
      chk_log("wait_grant", grant_log, 0, 2);
      chk_log("wait_busy_len", run_log, 0, 12);
      chk("wait_p2_beats", 128'(rdy_cnt[2]), 128'(2));

      // Reset in the middle of a 4-beat burst.
      clear_logs();
      pend[0].push_back(3);
      begin
         int n;
         n = 0;
         while (rdy_cnt[0] < 2 && n < 20) begin step(); n++; end
         chk("midrst_reach_beat2", 128'(rdy_cnt[0]), 128'(2));
      end
      rst_drive = 1'b1;
      step();
      chk("midrst_no_ready", 128'(iresps[0].ready), 128'(0));
      pend[0].delete();
      rst_drive = 1'b0;
      step();
      chk("midrst_oreq_valid", 128'(oreq.valid), 128'(0));
      chk("midrst_state", 128'(dut.state_q), 128'(IDLE));
      chk("midrst_ptr", 128'(dut.ptr_q), 128'(0));
      chk("midrst_p0_beats", 128'(rdy_cnt[0]), 128'(2));

      // Fairness: all three ports continuously valid with single-beat requests.
      do_reset();
      clear_logs();
      for (int i = 0; i < NP; i++) begin pend[i].push_back(0); pend[i].push_back(0); end
      drain(80);
      for (int k = 0; k < 6; k++) chk_log("fair_grant", grant_log, k, k % NP);
      for (int k = 0; k < 5; k++) chk_log("fair_gap", gap_log, k, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
